// File: rtl/step_enable_ctrl.sv
// Clock-enable generator for a single-clock MIPS datapath: turns slow-clock rises
// (free-run) or debounced button presses (single-step) into one-cycle enable pulses.
module step_enable_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 32
) (
    input  logic             Clk_in,
    input  logic             Reset,
    input  logic             Slow_in,
    input  logic             Step_btn,
    input  logic             Run_mode,
    input  logic             Halt,
    output logic             En_out,
    output logic [CNT_W-1:0] Cycle_cnt,
    output logic             Halted,
    output logic [1:0]       State_dbg
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_STEP = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   pulse_d;

    logic s1;
    logic s2;
    logic s3;
    logic slow_rise;

    logic            b1;
    logic            b2;
    logic            btn_stable;
    logic            btn_prev;
    logic [DB_W-1:0] db_cnt;
    logic            press;

    // Slow clock: two-flop synchronizer plus a history flop for rise detection.
    always_ff @(posedge Clk_in) begin
        if (Reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= Slow_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign slow_rise = s2 & ~s3;

    // Button: synchronize, then accept a new level only after it has held
    // for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
    always_ff @(posedge Clk_in) begin
        if (Reset) begin
            b1         <= 1'b0;
            b2         <= 1'b0;
            btn_stable <= 1'b0;
            btn_prev   <= 1'b0;
            db_cnt     <= '0;
        end else begin
            b1       <= Step_btn;
            b2       <= b1;
            btn_prev <= btn_stable;
            if (b2 == btn_stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_stable <= b2;
                db_cnt     <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    assign press = btn_stable & ~btn_prev;

    always_ff @(posedge Clk_in) begin
        if (Reset) begin
            state_q <= S_STEP;
        end else begin
            state_q <= state_d;
        end
    end

    // Priority: Halt, then mode change, then the pulse condition of the
    // current mode. Events belonging to the other mode are simply dropped.
    always_comb begin
        state_d = state_q;
        pulse_d = 1'b0;
        if (Halt) begin
            state_d = S_HALT;
        end else begin
            case (state_q)
                S_STEP: begin
                    if (Run_mode) begin
                        state_d = S_RUN;
                    end else if (press) begin
                        pulse_d = 1'b1;
                    end
                end
                S_RUN: begin
                    if (!Run_mode) begin
                        state_d = S_STEP;
                    end else if (slow_rise) begin
                        pulse_d = 1'b1;
                    end
                end
                S_HALT: begin
                    state_d = S_HALT;
                end
                default: begin
                    state_d = S_STEP;
                end
            endcase
        end
    end

    always_ff @(posedge Clk_in) begin
        if (Reset) begin
            En_out    <= 1'b0;
            Cycle_cnt <= '0;
        end else begin
            En_out <= pulse_d;
            if (pulse_d) begin
                Cycle_cnt <= Cycle_cnt + CNT_W'(1);
            end
        end
    end

    assign Halted    = (state_q == S_HALT);
    assign State_dbg = state_q;

endmodule

// File: tb/tb_step_enable_ctrl.sv
// Directed bench for step_enable_ctrl: free-run latency, debounce, halt,
// mode-change priority, reset behaviour and counter wrap.
module tb_step_enable_ctrl;

  logic       Clk_in;
  logic       Reset;
  logic       Slow_in;
  logic       Step_btn;
  logic       Run_mode;
  logic       Halt;
  logic       En_out;
  logic [3:0] Cycle_cnt;
  logic       Halted;
  logic [1:0] State_dbg;

  int checks;
  int failures;
  int pulse_cnt;
  int run_len;
  int max_run;
  int p0;

  logic [3:0] exp_q[$];
  logic [3:0] exp_v;

  step_enable_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(4)
  ) dut (
    .Clk_in(Clk_in),
    .Reset(Reset),
    .Slow_in(Slow_in),
    .Step_btn(Step_btn),
    .Run_mode(Run_mode),
    .Halt(Halt),
    .En_out(En_out),
    .Cycle_cnt(Cycle_cnt),
    .Halted(Halted),
    .State_dbg(State_dbg)
  );

  // clock
  initial begin
    Clk_in = 1'b0;
    forever #5 Clk_in = ~Clk_in;
  end

  // pulse monitor, sampled on the falling edge
  initial begin
    pulse_cnt = 0;
    run_len = 0;
    max_run = 0;
  end

  always @(negedge Clk_in) begin
    if (En_out === 1'b1) begin
      pulse_cnt <= pulse_cnt + 1;
      run_len <= run_len + 1;
      if (run_len + 1 > max_run) max_run <= run_len + 1;
    end else begin
      run_len <= 0;
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk_in);
      #1;
    end
  endtask

  task automatic do_reset();
    Slow_in = 1'b0;
    Step_btn = 1'b0;
    Run_mode = 1'b0;
    Halt = 1'b0;
    Reset = 1'b1;
    tick(3);
    Reset = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    Reset = 1'b1;
    Slow_in = 1'b0;
    Step_btn = 1'b0;
    Run_mode = 1'b0;
    Halt = 1'b0;
    #1;

    // reset state
    do_reset();
    check("rst_en", 32'(En_out), 32'd0);
    check("rst_cnt", 32'(Cycle_cnt), 32'd0);
    check("rst_halted", 32'(Halted), 32'd0);
    check("rst_state", 32'(State_dbg), 32'd0);

    // free-run: latency of first rise, then five rises total
    Run_mode = 1'b1;
    tick(2);
    check("run_state", 32'(State_dbg), 32'd1);
    p0 = pulse_cnt;
    Slow_in = 1'b1;
    tick(1);
    check("lat_k", 32'(En_out), 32'd0);
    tick(1);
    check("lat_k1", 32'(En_out), 32'd0);
    tick(1);
    check("lat_k2", 32'(En_out), 32'd1);
    check("lat_cnt", 32'(Cycle_cnt), 32'd1);
    tick(1);
    check("lat_k3", 32'(En_out), 32'd0);
    tick(6);
    for (int i = 0; i < 4; i++) begin
      Slow_in = 1'b0;
      tick(10);
      Slow_in = 1'b1;
      tick(10);
    end
    check("run_pulses", 32'(pulse_cnt - p0), 32'd5);
    check("run_cnt", 32'(Cycle_cnt), 32'd5);

    // step mode: bouncy press, long hold, release
    do_reset();
    tick(1);
    p0 = pulse_cnt;
    Step_btn = 1'b1;
    tick(1);
    Step_btn = 1'b0;
    tick(1);
    Step_btn = 1'b1;
    tick(20);
    check("bounce_pulses", 32'(pulse_cnt - p0), 32'd1);
    Step_btn = 1'b0;
    tick(20);
    check("release_pulses", 32'(pulse_cnt - p0), 32'd1);
    check("step_cnt", 32'(Cycle_cnt), 32'd1);

    // debounce boundary: 3 cycles rejected, 4 cycles accepted
    do_reset();
    tick(1);
    p0 = pulse_cnt;
    Step_btn = 1'b1;
    tick(3);
    Step_btn = 1'b0;
    tick(20);
    check("short_pulses", 32'(pulse_cnt - p0), 32'd0);
    check("short_cnt", 32'(Cycle_cnt), 32'd0);
    Step_btn = 1'b1;
    tick(4);
    Step_btn = 1'b0;
    tick(20);
    check("min_pulses", 32'(pulse_cnt - p0), 32'd1);
    check("min_cnt", 32'(Cycle_cnt), 32'd1);

    // reset coinciding with a pulse, and reset during a pulse
    do_reset();
    Run_mode = 1'b1;
    tick(2);
    Slow_in = 1'b1;
    tick(2);
    Reset = 1'b1;
    tick(1);
    check("rst_coinc_en", 32'(En_out), 32'd0);
    check("rst_coinc_cnt", 32'(Cycle_cnt), 32'd0);
    do_reset();
    Run_mode = 1'b1;
    tick(2);
    Slow_in = 1'b1;
    tick(3);
    check("mid_en_hi", 32'(En_out), 32'd1);
    check("mid_cnt_hi", 32'(Cycle_cnt), 32'd1);
    Reset = 1'b1;
    tick(1);
    check("mid_en_rst", 32'(En_out), 32'd0);
    check("mid_cnt_rst", 32'(Cycle_cnt), 32'd0);

    // halt on the same cycle as slow_rise; sticky until reset
    do_reset();
    Run_mode = 1'b1;
    tick(2);
    Slow_in = 1'b1;
    tick(10);
    Slow_in = 1'b0;
    tick(5);
    Slow_in = 1'b1;
    tick(2);
    Halt = 1'b1;
    tick(1);
    check("halt_en", 32'(En_out), 32'd0);
    check("halt_flag", 32'(Halted), 32'd1);
    check("halt_state", 32'(State_dbg), 32'd2);
    check("halt_cnt", 32'(Cycle_cnt), 32'd1);
    Halt = 1'b0;
    p0 = pulse_cnt;
    for (int i = 0; i < 2; i++) begin
      Slow_in = 1'b0;
      tick(5);
      Slow_in = 1'b1;
      tick(5);
    end
    Run_mode = 1'b0;
    Step_btn = 1'b1;
    tick(8);
    Step_btn = 1'b0;
    tick(10);
    check("halt_pulses", 32'(pulse_cnt - p0), 32'd0);
    check("halt_sticky", 32'(Halted), 32'd1);
    do_reset();
    check("unhalt_flag", 32'(Halted), 32'd0);
    check("unhalt_cnt", 32'(Cycle_cnt), 32'd0);
    check("unhalt_state", 32'(State_dbg), 32'd0);

    // Run_mode 1->0 on the slow_rise cycle, then a press
    Run_mode = 1'b1;
    tick(2);
    p0 = pulse_cnt;
    Slow_in = 1'b1;
    tick(2);
    Run_mode = 1'b0;
    tick(1);
    check("mode_en", 32'(En_out), 32'd0);
    check("mode_state", 32'(State_dbg), 32'd0);
    tick(5);
    check("mode_pulses", 32'(pulse_cnt - p0), 32'd0);
    Step_btn = 1'b1;
    tick(8);
    Step_btn = 1'b0;
    tick(10);
    check("mode_press", 32'(pulse_cnt - p0), 32'd1);
    check("mode_cnt", 32'(Cycle_cnt), 32'd1);

    // press while in S_RUN is discarded, not queued
    Run_mode = 1'b1;
    tick(2);
    Step_btn = 1'b1;
    tick(8);
    Step_btn = 1'b0;
    tick(10);
    Run_mode = 1'b0;
    tick(5);
    check("run_press_drop", 32'(pulse_cnt - p0), 32'd1);
    check("run_press_cnt", 32'(Cycle_cnt), 32'd1);

    // 17 pulses through a 4-bit counter
    do_reset();
    Run_mode = 1'b1;
    tick(2);
    for (int i = 1; i <= 17; i++) exp_q.push_back(4'(i % 16));
    for (int i = 0; i < 17; i++) begin
      Slow_in = 1'b1;
      tick(3);
      exp_v = exp_q.pop_front();
      check("wrap_en_hi", 32'(En_out), 32'd1);
      check("wrap_cnt", 32'(Cycle_cnt), 32'(exp_v));
      tick(1);
      check("wrap_en_lo", 32'(En_out), 32'd0);
      tick(1);
      Slow_in = 1'b0;
      tick(5);
    end
    check("wrap_final", 32'(Cycle_cnt), 32'd1);
    check("pulse_width", 32'(max_run), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
